// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: four-digit BCD stopwatch (SS.hh, 00.00 - 59.99).
// A prescaler divides clk down to the count tick. The four BCD digits
// increment as a cascade on every tick while running. Start/stop and
// clear arrive as single-cycle pulses.
//
// Optional feature macro: LAP_HOLD_EN
//   defined   - a display register sits between the counter and the digit
//               outputs, and lap pulses freeze/unfreeze the shown value.
//   undefined - lap is ignored, held is tied low, and the digits are the
//               counter registers themselves.

module stopwatch_bcd #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       overflow,
  output logic       held
);

  // Prescaler geometry. DIV is expected to be >= 2.
  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   count_q, count_d;   // {tens_s, units_s, tenths, hundredths}
  logic [3:0]    at_max;             // per-digit "would roll over on carry"
  logic          tick;
  logic          wrap;
  logic          overflow_q, overflow_d;
  logic          running_q;

  // Tick fires on the last prescaler phase while running; the counter
  // increments and the prescaler wraps on the same edge.
  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // A full wrap happens only when every digit is at its maximum (59.99).
  assign wrap = tick && (&at_max);

  // Run-state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear dominates, start_stop toggles run/pause.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler next value: advances only in RUN, holds its phase in PAUSE.
  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Cascaded BCD counter. Each digit rolls over when it sees a carry while
  // at its maximum (9, or 5 for the seconds-tens digit). Using >= for the
  // maximum test means an out-of-range value can never persist past a carry.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] MAX_VAL = (gi == 3) ? 4'd5 : 4'd9;
      logic carry_in;
      logic [3:0] cur;

      assign cur        = count_q[gi*4 +: 4];
      assign at_max[gi] = (cur >= MAX_VAL);

      if (gi == 0) begin : g_first
        assign carry_in = tick;
      end else begin : g_rest
        assign carry_in = tick & (&at_max[gi-1:0]);
      end

      assign count_d[gi*4 +: 4] = clear    ? 4'd0 :
                                  !carry_in ? cur  :
                                  at_max[gi] ? 4'd0 : cur + 4'd1;
    end
  endgenerate

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Sticky overflow: set by the 59.99 -> 00.00 wrap, dropped only by clear.
  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (wrap) begin
      overflow_d = 1'b1;
    end
  end

  // Status registers; running mirrors the next state so it is registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      running_q  <= (state_d == RUN);
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef LAP_HOLD_EN
  logic        held_q, held_d;
  logic [15:0] disp_q, disp_d;

  // Display capture: follows the counter's next value unless frozen. A lap
  // that freezes captures the current (pre-increment) count; a lap that
  // unfreezes resumes tracking on the same edge.
  always_comb begin
    held_d = held_q;
    disp_d = count_d;
    if (clear) begin
      held_d = 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      if (!held_q) begin
        held_d = 1'b1;
        disp_d = count_q;
      end else begin
        held_d = 1'b0;
      end
    end else if (held_q) begin
      disp_d = disp_q;
    end
  end

  // Display and hold-flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      held_q <= 1'b0;
      disp_q <= '0;
    end else begin
      held_q <= held_d;
      disp_q <= disp_d;
    end
  end

  assign held   = held_q;
  assign digit0 = disp_q[3:0];
  assign digit1 = disp_q[7:4];
  assign digit2 = disp_q[11:8];
  assign digit3 = disp_q[15:12];
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign held       = 1'b0;
  assign digit0     = count_q[3:0];
  assign digit1     = count_q[7:4];
  assign digit2     = count_q[11:8];
  assign digit3     = count_q[15:12];
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed testbench for stopwatch_bcd with CLK_HZ=10, TICK_HZ=1 (DIV=10).
// Lap-hold scenarios are selected by the LAP_HOLD_EN macro, matching the DUT.

module tb_stopwatch_bcd;

  logic       clk;
  logic       reset_n;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, overflow, held;
  logic [15:0] shown;

  int checks_cnt;
  int errors_cnt;

  stopwatch_bcd #(
    .CLK_HZ (10),
    .TICK_HZ(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .running   (running),
    .overflow  (overflow),
    .held      (held)
  );

  assign shown = {digit3, digit2, digit1, digit0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports the outcome on one line.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    step(1);
    lap = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset_n    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;

    // Reset held for 3 cycles while start_stop toggles.
    for (int i = 0; i < 3; i++) begin
      start_stop = (i % 2 == 0);
      step(1);
    end
    start_stop = 1'b0;
    check_val("rst_digits", shown, 16'h0000);
    check_val("rst_running", running, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_held", held, 0);
    reset_n = 1'b1;
    step(2);
    check_val("idle_digits", shown, 16'h0000);

    // Run: first increment DIV cycles after the start pulse.
    pulse_ss();
    check_val("run_running", running, 1);
    check_val("run_start_digits", shown, 16'h0000);
    step(9);
    check_val("run_pre_first_tick", shown, 16'h0000);
    step(1);
    check_val("run_first_tick", shown, 16'h0001);
    step(9);
    check_val("run_pre_second_tick", shown, 16'h0001);
    step(1);
    check_val("run_second_tick", shown, 16'h0002);
    step(12320);
    check_val("run_12_34", shown, 16'h1234);

    // Pause 4 cycles after a tick, wait, resume: phase is kept.
    step(3);
    pulse_ss();
    check_val("pause_running", running, 0);
    check_val("pause_digits", shown, 16'h1234);
    step(50);
    check_val("pause_hold_digits", shown, 16'h1234);
    pulse_ss();
    check_val("resume_running", running, 1);
    step(5);
    check_val("resume_pre_tick", shown, 16'h1234);
    step(1);
    check_val("resume_tick6", shown, 16'h1235);

    // Wrap 59.99 -> 00.00 with sticky overflow.
    step(47640);
    check_val("wrap_59_99", shown, 16'h5999);
    check_val("wrap_pre_overflow", overflow, 0);
    step(9);
    check_val("wrap_pre_tick", shown, 16'h5999);
    step(1);
    check_val("wrap_digits", shown, 16'h0000);
    check_val("wrap_overflow", overflow, 1);
    check_val("wrap_running", running, 1);

    // Priority: clear with start_stop at 07.50 -> IDLE.
    step(7500);
    check_val("prio_07_50", shown, 16'h0750);
    check_val("prio_overflow_sticky", overflow, 1);
    clear      = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear      = 1'b0;
    start_stop = 1'b0;
    check_val("prio_digits", shown, 16'h0000);
    check_val("prio_running", running, 0);
    check_val("prio_overflow_clr", overflow, 0);
    step(20);
    check_val("prio_idle_stays", shown, 16'h0000);

    // Tick coincident with start_stop: increment applied, then paused.
    pulse_ss();
    step(9);
    pulse_ss();
    check_val("tick_ss_digits", shown, 16'h0001);
    check_val("tick_ss_running", running, 0);
    step(30);
    check_val("tick_ss_paused", shown, 16'h0001);
    pulse_clear();
    check_val("clear_from_pause", shown, 16'h0000);

    // Tick coincident with clear: clear wins.
    pulse_ss();
    step(9);
    pulse_clear();
    check_val("tick_clear_digits", shown, 16'h0000);
    check_val("tick_clear_running", running, 0);
    step(15);
    check_val("tick_clear_idle", shown, 16'h0000);

    // Back-to-back start_stop pulses toggle every cycle.
    start_stop = 1'b1;
    step(1);
    check_val("b2b_first", running, 1);
    step(1);
    check_val("b2b_second", running, 0);
    start_stop = 1'b0;
    pulse_clear();

`ifdef LAP_HOLD_EN
    // Lap in IDLE is ignored.
    pulse_lap();
    check_val("lap_idle_held", held, 0);
    pulse_ss();
    step(3210);
    check_val("lap_03_21", shown, 16'h0321);
    pulse_lap();
    check_val("lap_freeze_digits", shown, 16'h0321);
    check_val("lap_freeze_held", held, 1);
    step(999);
    check_val("lap_frozen_100ticks", shown, 16'h0321);
    pulse_lap();
    check_val("lap_release_digits", shown, 16'h0421);
    check_val("lap_release_held", held, 0);
    step(8);
    // Lap on a tick edge captures the pre-increment count.
    pulse_lap();
    check_val("lap_tick_capture", shown, 16'h0421);
    check_val("lap_tick_held", held, 1);
    step(10);
    check_val("lap_tick_frozen", shown, 16'h0421);
    pulse_lap();
    check_val("lap_track_again", shown, 16'h0423);
    pulse_lap();
    check_val("lap_rehold", held, 1);
    pulse_clear();
    check_val("lap_clear_held", held, 0);
    check_val("lap_clear_digits", shown, 16'h0000);
`else
    // Without the feature, lap never freezes the digits.
    pulse_lap();
    check_val("nolap_idle_held", held, 0);
    pulse_ss();
    step(9);
    pulse_lap();
    check_val("nolap_tick_digits", shown, 16'h0001);
    check_val("nolap_held", held, 0);
    step(9);
    pulse_lap();
    check_val("nolap_tracking", shown, 16'h0002);
    step(10);
    check_val("nolap_tracking2", shown, 16'h0003);
    check_val("nolap_held2", held, 0);
    pulse_clear();
`endif

    // Reset mid-count.
    pulse_ss();
    step(25);
    check_val("midrst_pre", shown, 16'h0002);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check_val("midrst_digits", shown, 16'h0000);
    check_val("midrst_running", running, 0);
    step(20);
    check_val("midrst_idle", shown, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Four-digit BCD stopwatch counting seconds and hundredths (SS.hh, 00.00–59.99). Its four digit outputs drive the four BCD digit inputs of the quad seven-segment display multiplexer directly downstream. Internal prescaler derives the count tick from the system clock. Start/stop and clear come from already-debounced single-cycle button pulses.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV ≥ 2
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- start_stop  input  1  one-cycle pulse, toggles run/pause
- clear  input  1  one-cycle pulse, return to zero/idle
- lap  input  1  one-cycle pulse, toggles display hold (functional only with LAP_HOLD_EN)
- digit0  output  4  hundredths units, 0–9
- digit1  output  4  tenths, 0–9
- digit2  output  4  seconds units, 0–9
- digit3  output  4  seconds tens, 0–5
- running  output  1  high in RUN
- overflow  output  1  sticky, set on 59.99→00.00 wrap
- held  output  1  high while display frozen by lap

## Operation
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN.
  - Any state + clear → IDLE.
- Priority: reset_n low > clear > start_stop. Clear with start_stop in the same cycle → IDLE; start_stop ignored.
- On entry to IDLE via clear: counter digits → 0, prescaler → 0, overflow → 0, held → 0.
- Prescaler is a ceil(log2(DIV))-bit counter.
  - Increments only in RUN.
  - Holds its value in PAUSE, so resume keeps sub-tick phase.
  - Wraps DIV-1 → 0.
- Tick: prescaler == DIV-1 while in RUN.
- On a tick edge the counter increments as cascaded BCD:
  - digit0 9→0 carries to digit1.
  - digit1 9→0 carries to digit2.
  - digit2 9→0 carries to digit3.
  - digit3 5→0 (i.e. 59.99→00.00) sets overflow; counting continues from 00.00.
- Digits never hold non-BCD values. digit3 never exceeds 5.
- Tick coincident with start_stop in RUN: the increment is applied and the state moves to PAUSE on the same edge.
- Tick coincident with clear: clear wins, digits = 0.
- running = (state == RUN).

## Timing
- All outputs registered. Reset values: digits 0, running 0, overflow 0, held 0. State IDLE, prescaler 0.
- Reset has effect on the first rising edge with reset_n low, including mid-count and mid-hold.
- start_stop/clear sampled at edge N; running and digits reflect the result after edge N (visible in cycle N+1).
- From IDLE, a start_stop at edge N gives the first increment at edge N+DIV. The increment then repeats every DIV RUN cycles.
- Overflow rises in the same cycle digits show 00.00 after the wrap.
- No minimum spacing between pulses; back-to-back start_stop pulses toggle on each cycle.

## Configuration
- LAP_HOLD_EN defined:
  - A display register sits between the counter and the digit outputs.
  - lap pulse in RUN or PAUSE with held = 0: captures the current counter value, held → 1. Digits then show the frozen value while the counter continues.
  - lap pulse with held = 1: held → 0; digits track the counter from the next cycle.
  - lap is ignored in IDLE.
  - Clear or reset: held → 0.
  - Lap coincident with a tick: the captured value is the pre-increment count.
- LAP_HOLD_EN undefined:
  - lap is ignored; held is tied to 0.
  - Digits are the counter registers directly; no display register.

## Test plan
(Bench uses CLK_HZ=10, TICK_HZ=1, so DIV=10.)
- Reset: hold reset_n low 3 cycles with start_stop pulsing -> all digits 0, running 0, overflow 0, held 0.
- Run: start_stop pulse, run 1234 ticks (12340 cycles) -> digits 3,2,1,4 = 12.34. digit0 increments exactly every 10 cycles; first increment is 10 cycles after the pulse.
- Pause/resume: pause 4 cycles after a tick, wait 50 cycles, resume -> no change while paused. The next increment comes 6 cycles after resume.
- Wrap: run to 59.99, one more tick -> digits 00.00, overflow 1, running 1. Clear -> overflow 0, IDLE.
- Priority: clear and start_stop in the same cycle during RUN at 07.50 -> IDLE, digits 0, running 0. Tick coincident with start_stop -> increment applied, running 0.
- Lap (LAP_HOLD_EN): lap at 03.21 -> digits stay 03.21, held 1 while counting continues. Lap again 100 ticks later -> digits show 04.21 next cycle, held 0. Without the macro, lap has no effect.
